// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and data requests onto an 8-bit RAM.
// Optional MEM_CTRL_RR_EN: alternating fetch/data priority after each completion.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_rdy,
   output logic [31:0] if_data,
   input  logic        mm_req,
   input  logic        mm_we,
   input  logic [1:0]  mm_len,
   input  logic [31:0] mm_addr,
   input  logic [31:0] mm_wdata,
   output logic        mm_rdy,
   output logic [31:0] mm_rdata,
   output logic [31:0] ram_a,
   output logic        ram_wr,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din,
   output logic        stl_mm
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      MM_BUSY = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q;
   logic [2:0]  len_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] buf_q;
   logic        if_rdy_q, mm_rdy_q;
   logic [31:0] if_data_q, mm_rdata_q;

   logic        busy, byte_act, last, rd_cap;
   logic        grant_if, grant_mm;
   logic [2:0]  mm_n;
   logic [1:0]  rd_idx;
   logic [31:0] asm_word;

`ifdef MEM_CTRL_RR_EN
   logic        prio_q;
`endif

   assign busy     = (state_q != IDLE);
   assign byte_act = busy && (cnt_q < len_q);
   assign last     = busy && (we_q ? (cnt_q == len_q - 3'd1)
                                   : (cnt_q == len_q));
   // Read data lags its address by one cycle, so byte cnt-1 arrives now
   assign rd_cap   = busy && !we_q && (cnt_q != 3'd0);
   assign rd_idx   = cnt_q[1:0] - 2'd1;
   assign mm_n     = (mm_len == 2'b00) ? 3'd1 :
                     (mm_len == 2'b01) ? 3'd2 : 3'd4;

   // Arbitration is suppressed while a rdy pulse is out, forcing an idle gap
   always_comb begin
      grant_if = 1'b0;
      grant_mm = 1'b0;
      if (state_q == IDLE && !if_rdy_q && !mm_rdy_q) begin
`ifdef MEM_CTRL_RR_EN
         grant_if = if_req && (!mm_req || prio_q);
`else
         grant_if = if_req && !mm_req;
`endif
         grant_mm = mm_req && !grant_if;
      end
   end

   // Assemble the word including the byte arriving this cycle
   always_comb begin
      asm_word = buf_q;
      if (rd_cap) asm_word[{rd_idx, 3'b000} +: 8] = ram_din;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant_mm)      state_d = MM_BUSY;
            else if (grant_if) state_d = IF_BUSY;
         end
         IF_BUSY, MM_BUSY: begin
            if (last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM-side outputs, zero outside active byte cycles
   always_comb begin
      ram_a    = 32'd0;
      ram_wr   = 1'b0;
      ram_dout = 8'd0;
      if (byte_act) begin
         ram_a  = addr_q + {29'd0, cnt_q};
         ram_wr = we_q;
         if (we_q) ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      end
   end

   assign if_rdy   = if_rdy_q;
   assign mm_rdy   = mm_rdy_q;
   assign if_data  = if_data_q;
   assign mm_rdata = mm_rdata_q;
   assign stl_mm   = mm_req & ~mm_rdy_q;

   // Transaction datapath: latch on grant, step bytes, publish on completion
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= 3'd0;
         len_q      <= 3'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         buf_q      <= 32'd0;
         if_rdy_q   <= 1'b0;
         mm_rdy_q   <= 1'b0;
         if_data_q  <= 32'd0;
         mm_rdata_q <= 32'd0;
      end else begin
         if_rdy_q <= 1'b0;
         mm_rdy_q <= 1'b0;
         if (state_q == IDLE) begin
            cnt_q <= 3'd0;
            buf_q <= 32'd0;
            if (grant_mm) begin
               len_q   <= mm_n;
               we_q    <= mm_we;
               addr_q  <= mm_addr;
               wdata_q <= mm_wdata;
            end else if (grant_if) begin
               len_q   <= 3'd4;
               we_q    <= 1'b0;
               addr_q  <= if_addr;
               wdata_q <= 32'd0;
            end
         end else begin
            cnt_q <= cnt_q + 3'd1;
            if (rd_cap) buf_q <= asm_word;
            if (last) begin
               if (state_q == IF_BUSY) begin
                  if_rdy_q  <= 1'b1;
                  if_data_q <= asm_word;
               end else begin
                  mm_rdy_q <= 1'b1;
                  if (!we_q) mm_rdata_q <= asm_word;
               end
            end
         end
      end
   end

`ifdef MEM_CTRL_RR_EN
   // Priority flips toward fetch after data completes, back after fetch
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else if (last) begin
         prio_q <= (state_q == MM_BUSY);
      end
   end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: directed vector table, arbitration/reset sequences,
// and random transactions checked against a byte-array reference memory.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_rdy;
   logic [31:0] if_data;
   logic        mm_req, mm_we;
   logic [1:0]  mm_len;
   logic [31:0] mm_addr, mm_wdata;
   logic        mm_rdy;
   logic [31:0] mm_rdata;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic        stl_mm;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] ram [256];
   logic [7:0] ref_mem [256];

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdy(if_rdy), .if_data(if_data),
      .mm_req(mm_req), .mm_we(mm_we), .mm_len(mm_len),
      .mm_addr(mm_addr), .mm_wdata(mm_wdata),
      .mm_rdy(mm_rdy), .mm_rdata(mm_rdata),
      .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout),
      .ram_din(ram_din), .stl_mm(stl_mm)
   );

   // Synchronous RAM: read data appears the cycle after its address
   always @(posedge clk) begin
      if (ram_wr) ram[ram_a[7:0]] <= ram_dout;
      ram_din <= ram[ram_a[7:0]];
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input bit fetch, input bit [1:0] len);
      if (fetch) return 4;
      return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
      logic [31:0] w = 32'd0;
      for (int k = 0; k < n; k++) begin
         logic [31:0] ak = a + k;
         w[8*k +: 8] = ref_mem[ak[7:0]];
      end
      return w;
   endfunction

   // One transaction from a single requester; checks per-cycle RAM trace,
   // stall, latency and single-cycle rdy. Stores update the reference memory.
   task automatic txn(input bit fetch, input bit we, input bit [1:0] len,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] data);
      int n, lat, k, errs, exp_lat;
      bit done;
      logic [31:0] ea, ed;
      n = nbytes(fetch, len);
      exp_lat = (fetch || !we) ? n + 2 : n + 1;
      errs = 0; lat = 0; done = 0; data = 32'hx;
      @(negedge clk);
      if (fetch) begin
         if_req = 1; if_addr = addr;
      end else begin
         mm_req = 1; mm_we = we; mm_len = len;
         mm_addr = addr; mm_wdata = wdata;
      end
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         k = lat - 1;
         if (fetch ? if_rdy : mm_rdy) begin
            done = 1;
            if (ram_wr !== 0 || ram_a !== 0) errs++;
            if (!fetch && stl_mm !== 0) errs++;
            data = fetch ? if_data : mm_rdata;
         end else begin
            ea = (k < n) ? addr + k : 32'd0;
            ed = (we && k < n) ? ((wdata >> (8 * k)) & 32'hFF) : 32'd0;
            if (ram_a !== ea) errs++;
            if (ram_wr !== (we && k < n)) errs++;
            if ({24'd0, ram_dout} !== ed) errs++;
            if (!fetch && stl_mm !== 1) errs++;
            if (if_rdy !== 0 || mm_rdy !== 0) errs++;
         end
      end
      if_req = 0; mm_req = 0;
      if (fetch) if_addr = $urandom; else mm_addr = $urandom;
      @(posedge clk); #1;
      if (if_rdy !== 0 || mm_rdy !== 0) errs++;
      check("latency", lat, exp_lat);
      check("trace_errs", errs, 0);
      if (we && !fetch)
         for (int i = 0; i < n; i++) begin
            logic [31:0] ai = addr + i;
            ref_mem[ai[7:0]] = wdata[8*i +: 8];
         end
   endtask

   // Simultaneous fetch (0x100) and byte load; checks order, gap and data
   task automatic arb(input bit exp_if_first, input logic [31:0] mm_a,
                      input logic [31:0] exp_mm, input logic [31:0] exp_if);
      int t = 0, t_if = -1, t_mm = -1;
      logic [31:0] g_if = 32'hx, g_mm = 32'hx;
      @(negedge clk);
      mm_req = 1; mm_we = 0; mm_len = 2'b00; mm_addr = mm_a;
      if_req = 1; if_addr = 32'h100;
      while ((t_if < 0 || t_mm < 0) && t < 40) begin
         @(posedge clk); #1;
         t++;
         if (if_rdy) begin t_if = t; if_req = 0; g_if = if_data; end
         if (mm_rdy) begin t_mm = t; mm_req = 0; g_mm = mm_rdata; end
      end
      if_req = 0; mm_req = 0;
      check("arb_mm_time", t_mm, exp_if_first ? t_if + 4 : 3);
      check("arb_if_time", t_if, exp_if_first ? 6 : t_mm + 7);
      check("arb_mm_data", g_mm, exp_mm);
      check("arb_if_data", g_if, exp_if);
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          fetch;
      bit          we;
      bit [1:0]    len;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [31:0] d;
      bit rr;
`ifdef MEM_CTRL_RR_EN
      rr = 1;
`else
      rr = 0;
`endif
      for (int i = 0; i < 256; i++) begin
         logic [7:0] b;
         b = 8'(i) ^ 8'h5A;
         ref_mem[i] = b;
      end
      ref_mem[0] = 8'h11; ref_mem[1] = 8'h22;
      ref_mem[2] = 8'h33; ref_mem[3] = 8'h44;
      ref_mem[8'h40] = 8'h80;
      for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];

      vecs[0] = '{1, 0, 2'b10, 32'h100,      32'h0,        32'h44332211};
      vecs[1] = '{0, 1, 2'b01, 32'h20,       32'h0000BEEF, 32'h0};
      vecs[2] = '{0, 0, 2'b01, 32'h20,       32'h0,        32'h0000BEEF};
      vecs[3] = '{0, 0, 2'b00, 32'h40,       32'h0,        32'h00000080};
      vecs[4] = '{0, 0, 2'b10, 32'hFFFFFFFE, 32'h0,        32'h2211A5A4};
      vecs[5] = '{0, 1, 2'b00, 32'h41,       32'hFFFFFF33, 32'h0};
      vecs[6] = '{0, 0, 2'b10, 32'h40,       32'h0,        32'h19183380};
      vecs[7] = '{0, 1, 2'b11, 32'h10,       32'hCAFEF00D, 32'h0};
      vecs[8] = '{0, 0, 2'b11, 32'h10,       32'h0,        32'hCAFEF00D};

      rst = 1; if_req = 0; if_addr = 0;
      mm_req = 0; mm_we = 0; mm_len = 0; mm_addr = 0; mm_wdata = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_if_rdy", {31'd0, if_rdy}, 0);
      check("rst_mm_rdy", {31'd0, mm_rdy}, 0);
      check("rst_if_data", if_data, 0);
      check("rst_mm_rdata", mm_rdata, 0);
      check("rst_ram_a", ram_a, 0);
      check("rst_ram_wr_dout", {23'd0, ram_wr, ram_dout}, 0);
      check("rst_stl_mm", {31'd0, stl_mm}, 0);
      @(negedge clk); rst = 0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         txn(vecs[i].fetch, vecs[i].we, vecs[i].len,
             vecs[i].addr, vecs[i].wdata, d);
         if (!vecs[i].we) check($sformatf("vec%0d_data", i), d, vecs[i].exp);
      end
      check("if_data_hold", if_data, 32'h44332211);

      txn(1, 0, 2'b10, 32'h100, 32'h0, d);
      check("fetch_again", d, 32'h44332211);
      arb(0, 32'h40, 32'h00000080, 32'h44332211);
      txn(0, 1, 2'b00, 32'h60, 32'h55, d);
      arb(rr, 32'h60, 32'h00000055, 32'h44332211);

      // Reset during the third byte of a word store
      @(negedge clk);
      mm_req = 1; mm_we = 1; mm_len = 2'b10;
      mm_addr = 32'h80; mm_wdata = 32'hA1B2C3D4;
      repeat (3) @(posedge clk);
      #1;
      check("mid_store_byte2", {ram_wr, ram_a[30:0]}, 32'h80000082);
      rst = 1;
      @(posedge clk); #1;
      check("rst_mid_outs",
            {31'd0, |{if_rdy, mm_rdy, if_data, mm_rdata,
                      ram_a, ram_wr, ram_dout}}, 0);
      rst = 0; mm_req = 0;
      begin
         int seen = 0;
         repeat (4) begin
            @(posedge clk); #1;
            if (mm_rdy || ram_wr) seen++;
         end
         check("rst_no_rdy_wr", seen, 0);
      end
      check("rst_no_4th_byte", {24'd0, ram[8'h83]}, {24'd0, ref_mem[8'h83]});
      ref_mem[8'h80] = 8'hD4; ref_mem[8'h81] = 8'hC3; ref_mem[8'h82] = 8'hB2;
      txn(0, 0, 2'b10, 32'h80, 32'h0, d);
      check("after_rst_load", d, ref_read(32'h80, 4));

      for (int i = 0; i < 40; i++) begin
         bit f, w;
         bit [1:0] l;
         logic [31:0] a, wd, e;
         f  = ($urandom % 3) == 0;
         w  = f ? 1'b0 : 1'($urandom);
         l  = 2'($urandom);
         a  = $urandom;
         wd = $urandom;
         e  = ref_read(a, nbytes(f, l));
         txn(f, w, l, a, wd, d);
         if (!w) check($sformatf("rand%0d_data", i), d, e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
